// File: rtl/orbit_compositor.sv
// rtl/orbit_compositor.sv - frame-latched multi-object pixel compositor (optional COMPOSITOR_COLLIDE_EN)
module orbit_compositor #(
    parameter int NUM_OBJ  = 4,
    parameter int COORD_W  = 10,
    parameter int RADIUS   = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COORD_W-1:0]         next_x,
    input  logic [COORD_W-1:0]         next_y,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
    input  logic [NUM_OBJ*8-1:0]       obj_color,
    input  logic [NUM_OBJ-1:0]         obj_en,
    input  logic [7:0]                 bg_color,
    output logic [7:0]                 color_out,
    output logic                       frame_tick,
    output logic [15:0]                frame_count,
    output logic                       collide
);

    localparam logic [COORD_W:0]        H_LIM  = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0]        V_LIM  = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W-1:0]      H_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0]      V_LAST = COORD_W'(V_ACTIVE - 1);
    localparam logic signed [COORD_W:0] RAD    = (COORD_W+1)'(RADIUS);

    logic [COORD_W-1:0] sh_x_q     [NUM_OBJ];
    logic [COORD_W-1:0] sh_y_q     [NUM_OBJ];
    logic [7:0]         sh_color_q [NUM_OBJ];
    logic [NUM_OBJ-1:0] sh_en_q;

    logic [7:0]  color_q, color_d;
    logic        tick_q;
    logic [15:0] count_q;

    logic signed [COORD_W:0] dx [NUM_OBJ];
    logic signed [COORD_W:0] dy [NUM_OBJ];
    logic [NUM_OBJ-1:0]      hit;
    logic                    active;
    logic                    boundary;

    assign active   = ({1'b0, next_x} < H_LIM) && ({1'b0, next_y} < V_LIM);
    assign boundary = (next_x == H_LAST) && (next_y == V_LAST);

    // Per-object box test against the frame-latched shadows; signed, no wrap.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            dx[i]  = $signed({1'b0, next_x}) - $signed({1'b0, sh_x_q[i]});
            dy[i]  = $signed({1'b0, next_y}) - $signed({1'b0, sh_y_q[i]});
            hit[i] = sh_en_q[i] && (dx[i] <= RAD) && (dx[i] >= -RAD)
                                && (dy[i] <= RAD) && (dy[i] >= -RAD);
        end
    end

    // Lowest-index hit wins; background otherwise; black outside the active area.
    always_comb begin
        color_d = bg_color;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                color_d = sh_color_q[i];
            end
        end
        if (!active) begin
            color_d = 8'h00;
        end
    end

    // Shadow registers reload only on the edge closing the boundary pixel.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_x_q[i]     <= '0;
                sh_y_q[i]     <= '0;
                sh_color_q[i] <= '0;
            end
            sh_en_q <= '0;
        end else if (boundary) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_x_q[i]     <= obj_x[i*COORD_W +: COORD_W];
                sh_y_q[i]     <= obj_y[i*COORD_W +: COORD_W];
                sh_color_q[i] <= obj_color[i*8 +: 8];
            end
            sh_en_q <= obj_en;
        end
    end

    // Registered pixel colour, frame tick and frame counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            color_q <= 8'h00;
            tick_q  <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            color_q <= color_d;
            tick_q  <= boundary;
            if (boundary) begin
                count_q <= count_q + 16'h0001;
            end
        end
    end

    assign color_out   = color_q;
    assign frame_tick  = tick_q;
    assign frame_count = count_q;

`ifdef COMPOSITOR_COLLIDE_EN
    logic multi;
    logic acc_q, acc_d;
    logic collide_q, collide_d;

    // Two or more objects covering the same visible pixel.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (hit[i] && seen) begin
                multi = 1'b1;
            end
            seen = seen | hit[i];
        end
        multi = multi & active;
    end

    // Sticky accumulator; the boundary pixel's own overlap is folded into the result.
    always_comb begin
        acc_d     = acc_q | multi;
        collide_d = collide_q;
        if (boundary) begin
            collide_d = acc_q | multi;
            acc_d     = 1'b0;
        end
    end

    // Collision state; reset mid-frame discards the partial frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q     <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            collide_q <= collide_d;
        end
    end

    assign collide = collide_q;
`else
    assign collide = 1'b0;
`endif

endmodule
